// File: rtl/ioblock_bank.sv
// Bank of N configurable bidirectional I/O cells with a serial config chain
// and a shadow (active) config register, so shifting never disturbs the pads.
module ioblock_bank #(
   parameter int N    = 4,
   parameter int CFGB = 5
) (
   input  logic         IOCLK,
   input  logic         IORST,
   inout  wire  [N-1:0] PIN,
   input  logic [N-1:0] OUT,
   input  logic [N-1:0] TS,
   output logic [N-1:0] IN,
   input  logic         CE,
   input  logic         CFG_SI,
   input  logic         CFG_EN,
   input  logic         CFG_LD,
   output logic         CFG_SO,
   output logic         CFG_VALID
);
   localparam int L = CFGB * N;

   logic [L-1:0] shift;
   logic [L-1:0] active;
   logic [N-1:0] oe;
   logic [N-1:0] drv;

   // Load takes the pre-edge chain image even when a shift happens on the same edge.
   always_ff @(posedge IOCLK or posedge IORST) begin
      if (IORST) begin
         shift     <= '0;
         active    <= '0;
         CFG_VALID <= 1'b0;
      end else begin
         if (CFG_EN) shift <= {CFG_SI, shift[L-1:1]};
         if (CFG_LD) begin
            active    <= shift;
            CFG_VALID <= 1'b1;
         end
      end
   end

   assign CFG_SO = shift[0];

   for (genvar k = 0; k < N; k++) begin : g_cell
      ioblock_cell u_cell (
         .clk  (IOCLK),
         .rst  (IORST),
         .ce   (CE),
         .cfg  (active[CFGB*k +: CFGB]),
         .data (OUT[k]),
         .tsc  (TS[k]),
         .pad  (PIN[k]),
         .oe   (oe[k]),
         .drv  (drv[k]),
         .fab  (IN[k])
      );
      assign PIN[k] = oe[k] ? drv[k] : 1'bz;
   end
endmodule

// One I/O cell: optional output/tristate/input flops and the tristate mode mux.
// cfg: [1:0] tristate mode, [2] registered input, [3] registered output, [4] registered tristate.
module ioblock_cell (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   input  logic [4:0] cfg,
   input  logic       data,
   input  logic       tsc,
   input  logic       pad,
   output logic       oe,
   output logic       drv,
   output logic       fab
);
   logic oq, tq, dq;
   logic d_ts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oq <= 1'b0;
         tq <= 1'b0;
         dq <= 1'b0;
      end else if (ce) begin
         oq <= data;
         tq <= tsc;
         dq <= pad;
      end
   end

   assign drv  = cfg[3] ? oq : data;
   assign d_ts = cfg[4] ? tq : tsc;
   assign fab  = cfg[2] ? dq : pad;

   // Mode 10 treats the tristate control as an active-low enable.
   always_comb begin
      oe = 1'b0;
      case (cfg[1:0])
         2'b00: oe = 1'b0;
         2'b01: oe = d_ts;
         2'b10: oe = ~d_ts;
         2'b11: oe = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_ioblock_bank.sv
// Scoreboard bench for ioblock_bank: two daisy-chained banks, bank A on the pads
// under test, bank B fed from bank A's serial output.
module tb_ioblock_bank;
   localparam int N = 4;
   localparam logic [19:0] IMG_CHAIN = 20'h00003;  // cell0 mode 11
   localparam logic [19:0] IMG_MODES = 20'h00820;  // cell1 mode 01, cell2 mode 10
   localparam logic [19:0] IMG_REG   = 20'hE8000;  // cell3 TREG OREG DORREG, mode 01
   localparam logic [19:0] IMG_B     = 20'h00823;  // cell0 11, cell1 01, cell2 10
   localparam logic [19:0] IMG_A_D   = 20'h18000;  // cell3 mode 11

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wire  [N-1:0] pin_a, pin_b;
   logic [N-1:0] out_a, ts_a, out_b, ts_b, in_a, in_b, ext_en, ext_val;
   logic         ce, si, en, ld, so_a, so_b, vld_a, vld_b;

   for (genvar i = 0; i < N; i++) begin : g_ext
      assign pin_a[i] = ext_en[i] ? ext_val[i] : 1'bz;
   end

   ioblock_bank #(.N(N), .CFGB(5)) u_a (
      .IOCLK(clk), .IORST(rst), .PIN(pin_a), .OUT(out_a), .TS(ts_a), .IN(in_a),
      .CE(ce), .CFG_SI(si), .CFG_EN(en), .CFG_LD(ld), .CFG_SO(so_a), .CFG_VALID(vld_a)
   );
   ioblock_bank #(.N(N), .CFGB(5)) u_b (
      .IOCLK(clk), .IORST(rst), .PIN(pin_b), .OUT(out_b), .TS(ts_b), .IN(in_b),
      .CE(ce), .CFG_SI(so_a), .CFG_EN(en), .CFG_LD(ld), .CFG_SO(so_b), .CFG_VALID(vld_b)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      tag;
      int         kind;
      logic [3:0] val;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b", tag, got, exp);
      end
   endtask

   // Pad reads as 1 only when actually driven high; Z and 0 both read as 0.
   function automatic logic [3:0] pads(input logic [3:0] p);
      logic [3:0] o;
      for (int i = 0; i < 4; i++) o[i] = (p[i] === 1'b1);
      return o;
   endfunction

   function automatic logic [3:0] observe(input int kind);
      case (kind)
         0: return pads(pin_a);
         1: return in_a;
         2: return {3'b0, in_a[3]};
         3: return {3'b0, vld_a};
         4: return {3'b0, so_a};
         5: return pads(pin_b);
         6: return {3'b0, so_b};
         7: return {3'b0, vld_b};
         default: return 4'hx;
      endcase
   endfunction

   // Expected pads for unregistered cells given a config image.
   function automatic logic [3:0] mode_pins(input logic [19:0] img, input logic [3:0] o,
                                            input logic [3:0] t);
      logic [3:0] p;
      for (int k = 0; k < 4; k++) begin
         case (img[5*k +: 2])
            2'b00: p[k] = 1'b0;
            2'b01: p[k] = t[k] & o[k];
            2'b10: p[k] = ~t[k] & o[k];
            default: p[k] = o[k];
         endcase
      end
      return p;
   endfunction

   task automatic push(input string tag, input int kind, input logic [3:0] val);
      exp_t e;
      e.tag = tag; e.kind = kind; e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain;
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, observe(e.kind), e.val);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic shift_in(input logic [39:0] img, input int n);
      for (int i = 0; i < n; i++) begin
         si = img[i];
         en = 1'b1;
         step();
      end
      en = 1'b0;
      si = 1'b0;
   endtask

   task automatic load;
      ld = 1'b1;
      step();
      ld = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ext_en = '0; ext_val = '0;
      out_a = 4'b1111; ts_a = 4'($urandom);
      out_b = 4'b1111; ts_b = 4'b0000;
      ce = 1'($urandom); si = 1'($urandom); en = 1'($urandom); ld = 1'($urandom);
      #12;
      push("rst_pins", 0, 4'b0000);
      push("rst_valid", 3, 4'b0);
      push("rst_so", 4, 4'b0);
      drain();
      ext_en = 4'b1111; ext_val = 4'b1010;
      #1;
      push("rst_in", 1, 4'b1010);
      drain();
      ext_en = '0;
      ce = 1'b1; si = 1'b0; en = 1'b0; ld = 1'b0; ts_a = 4'b0000;
      @(negedge clk) rst = 1'b0;
      step();

      // chain load, cell0 always driving
      shift_in({20'b0, IMG_CHAIN}, 20);
      push("chain_preload_pins", 0, 4'b0000);
      push("chain_so", 4, 4'b0001);
      push("chain_valid_pre", 3, 4'b0);
      drain();
      load();
      push("chain_pins", 0, 4'b0001);
      push("chain_valid", 3, 4'b1);
      drain();
      out_a = 4'b1110; #1;
      push("chain_comb_lo", 0, 4'b0000);
      drain();
      out_a = 4'b1111; #1;
      push("chain_comb_hi", 0, 4'b0001);
      drain();

      // tristate modes 01 and 10
      shift_in({20'b0, IMG_MODES}, 20);
      load();
      ts_a = 4'b0110; #1;
      push("mode_ts0110", 0, mode_pins(IMG_MODES, out_a, ts_a));
      drain();
      ts_a = 4'b0000; #1;
      push("mode_ts0000", 0, mode_pins(IMG_MODES, out_a, ts_a));
      drain();

      // registered output, tristate and input on cell3
      out_a = 4'b0000; ts_a = 4'b1000;
      shift_in({20'b0, IMG_REG}, 20);
      load();
      push("reg_init", 0, 4'b0000);
      drain();
      out_a = 4'b1000; #1;
      push("reg_no_comb", 0, 4'b0000);
      drain();
      step();
      push("reg_out_edge", 0, 4'b1000);
      push("reg_in_lag", 2, 4'b0);
      drain();
      step();
      push("reg_in_edge", 2, 4'b1);
      drain();
      ce = 1'b0; out_a = 4'b0000; ts_a = 4'b0000;
      step(); step();
      push("ce0_pins", 0, 4'b1000);
      push("ce0_in", 2, 4'b1);
      drain();
      ce = 1'b1;
      step();
      push("ce1_ts_off", 0, 4'b0000);
      push("ce1_in", 2, 4'b1);
      drain();

      // simultaneous shift and load
      out_a = 4'b1111; ts_a = 4'b0110;
      shift_in({20'b0, IMG_MODES}, 20);
      push("shift_only_pins", 0, 4'b0000);
      drain();
      si = 1'b1; en = 1'b1; ld = 1'b1;
      step();
      si = 1'b0; en = 1'b0; ld = 1'b0;
      push("sim_preshift", 0, mode_pins(IMG_MODES, out_a, ts_a));
      drain();
      load();
      push("sim_postshift", 0, mode_pins({1'b1, IMG_MODES[19:1]}, out_a, ts_a));
      drain();

      // asynchronous reset mid-shift
      si = 1'b1; en = 1'b1;
      for (int i = 0; i < 7; i++) step();
      #3 rst = 1'b1;
      #1;
      push("arst_pins", 0, 4'b0000);
      push("arst_valid", 3, 4'b0);
      push("arst_so", 4, 4'b0);
      drain();
      en = 1'b0; si = 1'b0;
      step();
      rst = 1'b0;
      shift_in({20'b0, IMG_CHAIN}, 20);
      push("arst_preload_valid", 3, 4'b0);
      push("arst_preload_pins", 0, 4'b0000);
      drain();
      load();
      push("arst_reload_pins", 0, 4'b0001);
      push("arst_reload_valid", 3, 4'b1);
      drain();

      // daisy chain of two banks
      ts_a = 4'b0000; ts_b = 4'b0000; out_b = 4'b1111;
      shift_in({IMG_A_D, IMG_B}, 40);
      push("daisy_far_so", 6, {3'b0, IMG_B[0]});
      push("daisy_preload_a", 0, 4'b0001);
      drain();
      load();
      push("daisy_a_pins", 0, mode_pins(IMG_A_D, out_a, ts_a));
      push("daisy_b_pins", 5, mode_pins(IMG_B, out_b, ts_b));
      push("daisy_b_valid", 7, 4'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
